// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: FSM states, ALU op codes
// and the legality check applied before an operation is launched.
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1011;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1111;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SUB,
            OP_SLT, OP_SRL, OP_NOR, OP_MUL: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on contention the
// requester that was not served last wins.
module alu_share_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // Grant decode from request valids and the last-served index
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters, one operation
// in flight, with valid/ready request and response channels.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic [4:0]       req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    input  logic [4:0]       req1_shamt,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e                      state_r, state_s;
    logic                        last_r, last_s;
    logic                        owner_r, owner_s;
    logic [CNT_W-1:0]            count_r, count_s;
    logic [WIDTH-1:0]            alu_a_s, alu_b_s;
    logic [3:0]                  alu_control_s;
    logic [4:0]                  alu_shamt_s;
    logic [1:0]                  rsp_valid_r, rsp_valid_s;
    logic [1:0][WIDTH-1:0]       rsp_result_r, rsp_result_s;
    logic [1:0]                  rsp_zero_r, rsp_zero_s;
    logic [1:0]                  rsp_err_r, rsp_err_s;
    logic [1:0]                  rsp_ready_s;
    logic [1:0]                  grant_s;
    logic                        accept_s;
    logic [WIDTH-1:0]            sel_a_s, sel_b_s;
    logic [3:0]                  sel_op_s;
    logic [4:0]                  sel_shamt_s;

    alu_share_arbiter_rr_arb2 u_rr_arb2 (
        .valid (({req1_valid, req0_valid})),
        .last  (last_r),
        .grant (grant_s)
    );

    assign req0_ready  = (state_r == ST_IDLE) & grant_s[0];
    assign req1_ready  = (state_r == ST_IDLE) & grant_s[1];
    assign accept_s    = (req0_ready & req0_valid) | (req1_ready & req1_valid);
    assign rsp_ready_s = {rsp1_ready, rsp0_ready};

    assign sel_a_s     = grant_s[1] ? req1_a     : req0_a;
    assign sel_b_s     = grant_s[1] ? req1_b     : req0_b;
    assign sel_op_s    = grant_s[1] ? req1_op    : req0_op;
    assign sel_shamt_s = grant_s[1] ? req1_shamt : req0_shamt;

    assign rsp0_valid  = rsp_valid_r[0];
    assign rsp0_result = rsp_result_r[0];
    assign rsp0_zero   = rsp_zero_r[0];
    assign rsp0_err    = rsp_err_r[0];
    assign rsp1_valid  = rsp_valid_r[1];
    assign rsp1_result = rsp_result_r[1];
    assign rsp1_zero   = rsp_zero_r[1];
    assign rsp1_err    = rsp_err_r[1];

    // Next-state, operand latch, settle counter and response register logic
    always_comb begin
        state_s       = state_r;
        last_s        = last_r;
        owner_s       = owner_r;
        count_s       = count_r;
        alu_a_s       = alu_a;
        alu_b_s       = alu_b;
        alu_control_s = alu_control;
        alu_shamt_s   = alu_shamt;
        rsp_valid_s   = rsp_valid_r;
        rsp_result_s  = rsp_result_r;
        rsp_zero_s    = rsp_zero_r;
        rsp_err_s     = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    last_s  = grant_s[1];
                    owner_s = grant_s[1];
                    if (is_legal_op(sel_op_s)) begin
                        alu_a_s       = sel_a_s;
                        alu_b_s       = sel_b_s;
                        alu_control_s = sel_op_s;
                        alu_shamt_s   = sel_shamt_s;
                        count_s       = CNT_LOAD;
                        state_s       = ST_EXEC;
                    end else begin
                        // Illegal op never reaches the ALU; answer straight away
                        rsp_valid_s[grant_s[1]]  = 1'b1;
                        rsp_result_s[grant_s[1]] = {WIDTH{1'b0}};
                        rsp_zero_s[grant_s[1]]   = 1'b0;
                        rsp_err_s[grant_s[1]]    = 1'b1;
                        state_s                  = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (count_r == {CNT_W{1'b0}}) begin
                    rsp_valid_s[owner_r]  = 1'b1;
                    rsp_result_s[owner_r] = alu_result;
                    rsp_zero_s[owner_r]   = alu_zero;
                    rsp_err_s[owner_r]    = 1'b0;
                    state_s               = ST_RESP;
                end else begin
                    count_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (rsp_ready_s[owner_r]) begin
                    rsp_valid_s[owner_r] = 1'b0;
                    state_s              = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_r       <= 1'b1;
            owner_r      <= 1'b0;
            count_r      <= {CNT_W{1'b0}};
            alu_a        <= {WIDTH{1'b0}};
            alu_b        <= {WIDTH{1'b0}};
            alu_control  <= 4'b0000;
            alu_shamt    <= 5'b00000;
            rsp_valid_r  <= 2'b00;
            rsp_result_r <= {(2*WIDTH){1'b0}};
            rsp_zero_r   <= 2'b00;
            rsp_err_r    <= 2'b00;
        end else begin
            state_r      <= state_s;
            last_r       <= last_s;
            owner_r      <= owner_s;
            count_r      <= count_s;
            alu_a        <= alu_a_s;
            alu_b        <= alu_b_s;
            alu_control  <= alu_control_s;
            alu_shamt    <= alu_shamt_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_result_r <= rsp_result_s;
            rsp_zero_r   <= rsp_zero_s;
            rsp_err_r    <= rsp_err_s;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU beside the DUT.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic [4:0]  alu_shamt;
    logic        alu_zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_shamt(req1_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Reference combinational ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1111: alu_result = alu_a * alu_b;
            4'b0011: alu_result = alu_b << alu_shamt;
            4'b1011: alu_result = alu_b >> alu_shamt;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request on requester n and hold it until accepted
    task automatic send(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
        logic done;
        done = 1'b0;
        if (n == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if ((n == 0) ? req0_ready : req1_ready) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("accept", {31'd0, done}, 32'd1);
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // Wait for requester n's response, check it, stall, then consume it
    task automatic wait_rsp(input int n, input logic [31:0] exp_res, input logic exp_zero,
                            input logic exp_err, input int exp_edges, input int stall);
        logic got;
        int   edges;
        got   = 1'b0;
        edges = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((n == 0) ? rsp0_valid : rsp1_valid) got = 1'b1;
            else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        check("rsp_valid", {31'd0, got}, 32'd1);
        check("latency", edges, exp_edges);
        check("result", (n == 0) ? rsp0_result : rsp1_result, exp_res);
        check("zero", {31'd0, (n == 0) ? rsp0_zero : rsp1_zero}, {31'd0, exp_zero});
        check("err", {31'd0, (n == 0) ? rsp0_err : rsp1_err}, {31'd0, exp_err});
        check("other_valid", {31'd0, (n == 0) ? rsp1_valid : rsp0_valid}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("stall_valid", {31'd0, (n == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
            check("stall_result", (n == 0) ? rsp0_result : rsp1_result, exp_res);
            check("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        if (n == 0) rsp0_ready = 1'b1;
        else        rsp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        check("valid_drop", {31'd0, (n == 0) ? rsp0_valid : rsp1_valid}, 32'd0);
        check("result_hold", (n == 0) ? rsp0_result : rsp1_result, exp_res);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0; req0_shamt = 5'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0; req1_shamt = 5'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_ctl", {28'd0, alu_control}, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

        // 1: single ADD
        send(0, 4'b0010, 32'd4, 32'd1, 5'd0);
        check("alu_ctl_add", {28'd0, alu_control}, 32'h2);
        wait_rsp(0, 32'd5, 1'b0, 1'b0, 2, 0);

        // 2/3: contention after a fresh reset, req0 re-requests while req1 waits
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0110; req0_a = 32'd4; req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'b0111; req1_a = 32'd1; req1_b = 32'd4;
        #1;
        check("cont1_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_op = 4'b0010; req0_a = 32'd3; req0_b = 32'd5;
        wait_rsp(0, 32'd0, 1'b1, 1'b0, 2, 0);
        check("cont2_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(1, 32'd1, 1'b0, 1'b0, 2, 5);
        check("cont3_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(0, 32'd8, 1'b0, 1'b0, 2, 0);

        // 4: shifts and multiply
        send(1, 4'b0011, 32'd0, 32'd1, 5'd5);
        wait_rsp(1, 32'd32, 1'b0, 1'b0, 2, 0);
        send(1, 4'b1011, 32'd0, 32'h8000_0000, 5'd31);
        wait_rsp(1, 32'd1, 1'b0, 1'b0, 2, 0);
        send(0, 4'b1111, 32'd3, 32'd7, 5'd0);
        wait_rsp(0, 32'd21, 1'b0, 1'b0, 2, 0);

        // 5: illegal op answers immediately and leaves the ALU untouched
        send(0, 4'b0100, 32'd55, 32'd66, 5'd9);
        check("illegal_alu_ctl", {28'd0, alu_control}, 32'hF);
        check("illegal_alu_a", alu_a, 32'd3);
        wait_rsp(0, 32'd0, 1'b0, 1'b1, 0, 0);

        // 6: reset during EXEC
        send(0, 4'b0010, 32'd9, 32'd9, 5'd0);
        reset = 1'b1;
        #1;
        check("rst_exec_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("rst_exec_err", {31'd0, rsp0_err}, 32'd0);
        check("rst_exec_alu_a", alu_a, 32'd0);
        check("rst_exec_res", rsp1_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd2; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'd1; req1_b = 32'd2;
        #1;
        check("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(0, 32'd4, 1'b0, 1'b0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
